// File: rtl/rand_buf_pkg.sv
// rand_buf_pkg: register addresses, decode indices and CON/STAT field positions
// shared by the random-word buffer and its register decode.
package rand_buf_pkg;

  localparam logic [15:0] RNDBUF_CON_ADR  = 16'h0000;
  localparam logic [15:0] RNDBUF_STAT_ADR = 16'h0004;
  localparam logic [15:0] RNDBUF_DATA_ADR = 16'h0008;

  localparam int RV_CFG_RNDBUF_CON  = 0;
  localparam int RV_CFG_RNDBUF_STAT = 1;
  localparam int RV_CFG_RNDBUF_DATA = 2;
  localparam int RV_CFG_N           = 3;

  localparam int CON_EN_BIT     = 0;
  localparam int CON_FLUSH_BIT  = 1;
  localparam int CON_IEN_BIT    = 2;
  localparam int CON_DECIM_LSB  = 4;
  localparam int CON_THRESH_LSB = 8;

  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 12;
  localparam int STAT_UDF_BIT   = 13;

  typedef struct packed {
    logic       en;
    logic       ien;
    logic [3:0] decim;
    logic [2:0] thresh;
  } con_t;

endpackage

// File: rtl/rand_buf_if.sv
// rand_buf_if: ICB register bus bundle (write and read channels).
interface rand_buf_if #(
  parameter int AW = 8
) ();
  logic          icb_wr;
  logic [AW-1:0] icb_wadr;
  logic [31:0]   icb_wdat;
  logic          icb_wack;
  logic          icb_rd;
  logic [AW-1:0] icb_radr;
  logic [31:0]   icb_rdat;
  logic          icb_rack;

  modport master (
    output icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr,
    input  icb_wack, icb_rdat, icb_rack
  );

  modport slave (
    input  icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr,
    output icb_wack, icb_rdat, icb_rack
  );
endinterface

// File: rtl/rand_buf_fifo.sv
// rand_buf_fifo: DEPTH x 32 synchronous FIFO with push, pop and flush;
// a push while full is dropped unless a pop frees the slot in the same cycle.
module rand_buf_fifo #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [31:0]   wdat_i,
  output logic [31:0]   rdat_o,
  output logic [LW-1:0] level_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty_o   = (level_q == LW'(0));
  assign full_o    = (level_q == LW'(DEPTH));
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & ~flush_i & (~full_o | pop_ok_s);
  assign rdat_o    = mem_q[rptr_q];
  assign level_o   = level_q;

  // Pointer and level next-state; flush overrides both push and pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = PW'(0);
      rptr_d  = PW'(0);
      level_d = LW'(0);
    end else begin
      wptr_d  = push_ok_s ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop_ok_s ? rptr_q + PW'(1) : rptr_q;
      level_d = level_q + LW'(push_ok_s) - LW'(pop_ok_s);
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= PW'(0);
      rptr_q  <= PW'(0);
      level_q <= LW'(0);
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (push_ok_s) begin
      mem_q[wptr_q] <= wdat_i;
    end
  end

endmodule

// File: rtl/rand_buf.sv
// rand_buf: samples the LFSR generator output, decimates, buffers in a FIFO and serves it
// over ICB. Define RAND_BUF_WHITEN_EN to XOR each sample with the half-swapped previous raw word.
module rand_buf
  import rand_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  rand_buf_if.slave   icb,
  input  logic [31:0] rnd_dat,
  input  logic        rnd_vld,
  output logic        rnd_irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  function automatic logic [RV_CFG_N-1:0] icb_dec(input logic [AW-1:0] adr);
    logic [RV_CFG_N-1:0] sel;
    sel = {RV_CFG_N{1'b0}};
    sel[RV_CFG_RNDBUF_CON]  = (adr == AW'(RNDBUF_CON_ADR));
    sel[RV_CFG_RNDBUF_STAT] = (adr == AW'(RNDBUF_STAT_ADR));
    sel[RV_CFG_RNDBUF_DATA] = (adr == AW'(RNDBUF_DATA_ADR));
    return sel;
  endfunction

  con_t                con_q, con_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                irq_q, irq_d;
  logic [RV_CFG_N-1:0] wsel_s, rsel_s;
  logic                con_wr_s, stat_wr_s;
  logic                tick_s, flush_s, push_s, pop_s, pop_ok_s;
  logic                ovf_set_s, udf_set_s;
  logic [31:0]         sample_s, head_s, rdat_s;
  logic [LW-1:0]       level_s;
  logic                empty_s, full_s;
  logic                unused_wdat_s;

  assign wsel_s    = icb_dec(icb.icb_wadr);
  assign rsel_s    = icb_dec(icb.icb_radr);
  assign con_wr_s  = icb.icb_wr & wsel_s[RV_CFG_RNDBUF_CON];
  assign stat_wr_s = icb.icb_wr & wsel_s[RV_CFG_RNDBUF_STAT];
  assign flush_s   = con_wr_s & icb.icb_wdat[CON_FLUSH_BIT];
  assign pop_s     = icb.icb_rd & rsel_s[RV_CFG_RNDBUF_DATA];
  assign pop_ok_s  = pop_s & ~empty_s;
  assign push_s    = tick_s & ~flush_s;
  // A pop in the same cycle frees the slot, so only a genuinely blocked push counts as overflow.
  assign ovf_set_s = push_s & full_s & ~pop_ok_s;
  assign udf_set_s = pop_s & empty_s;

  assign unused_wdat_s = ^{icb.icb_wdat[31:14], icb.icb_wdat[11], icb.icb_wdat[3]};

`ifdef RAND_BUF_WHITEN_EN
  logic [31:0] prev_q, prev_d;

  // Last raw word taken on a tick; flush restarts the whitening chain.
  always_comb begin
    prev_d = prev_q;
    if (flush_s) begin
      prev_d = 32'd0;
    end else if (tick_s) begin
      prev_d = rnd_dat;
    end else begin
      prev_d = prev_q;
    end
  end

  // Whitening state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 32'd0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign sample_s = rnd_dat ^ {prev_q[15:0], prev_q[31:16]};
`else
  assign sample_s = rnd_dat;
`endif

  // Control register write; flush is a strobe and is not stored.
  always_comb begin
    con_d = con_q;
    if (con_wr_s) begin
      con_d.en     = icb.icb_wdat[CON_EN_BIT];
      con_d.ien    = icb.icb_wdat[CON_IEN_BIT];
      con_d.decim  = icb.icb_wdat[CON_DECIM_LSB +: 4];
      con_d.thresh = icb.icb_wdat[CON_THRESH_LSB +: 3];
    end else begin
      con_d = con_q;
    end
  end

  // Decimation counter; a tick fires when the count reaches decim.
  always_comb begin
    cnt_d  = cnt_q;
    tick_s = 1'b0;
    if (!con_q.en) begin
      cnt_d = 4'd0;
    end else if (rnd_vld) begin
      if (cnt_q == con_q.decim) begin
        tick_s = 1'b1;
        cnt_d  = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sticky flags (W1C, set wins) and threshold interrupt next-state.
  always_comb begin
    ovf_d = (ovf_q & ~(stat_wr_s & icb.icb_wdat[STAT_OVF_BIT])) | ovf_set_s;
    udf_d = (udf_q & ~(stat_wr_s & icb.icb_wdat[STAT_UDF_BIT])) | udf_set_s;
    irq_d = con_q.ien & (con_q.thresh != 3'd0) & (5'(level_s) >= 5'(con_q.thresh));
  end

  // Control, sampler, flag and interrupt registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      con_q <= con_t'(9'd0);
      cnt_q <= 4'd0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      con_q <= con_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      irq_q <= irq_d;
    end
  end

  rand_buf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .wdat_i  (sample_s),
    .rdat_o  (head_s),
    .level_o (level_s),
    .empty_o (empty_s),
    .full_o  (full_s)
  );

  // Read mux; DATA returns 0 when empty, unmapped addresses return 0.
  always_comb begin
    rdat_s = 32'd0;
    if (rsel_s[RV_CFG_RNDBUF_CON]) begin
      rdat_s = {21'd0, con_q.thresh, con_q.decim, 1'b0, con_q.ien, 1'b0, con_q.en};
    end else if (rsel_s[RV_CFG_RNDBUF_STAT]) begin
      rdat_s = {18'd0, udf_q, ovf_q, 2'd0, full_s, empty_s, 3'd0, 5'(level_s)};
    end else if (rsel_s[RV_CFG_RNDBUF_DATA]) begin
      rdat_s = empty_s ? 32'd0 : head_s;
    end else begin
      rdat_s = 32'd0;
    end
  end

  assign icb.icb_wack = icb.icb_wr;
  assign icb.icb_rack = icb.icb_rd;
  assign icb.icb_rdat = rdat_s;
  assign rnd_irq      = irq_q;

endmodule
